// File: rtl/uart_packet_rx_pkg.sv
// Shared definitions for the UART packet assembler: command-byte bit positions,
// mode/speed encodings and the assembler state type.
package uart_packet_rx_pkg;

    localparam int CMD_START  = 0;
    localparam int CMD_STOP   = 1;
    localparam int CMD_MODE   = 2;
    localparam int CMD_CH_LSB = 3;
    localparam int CMD_CH_MSB = 6;

    localparam logic ONE_SHOT   = 1'b0;
    localparam logic REPEAT     = 1'b1;
    localparam logic LOW_SPEED  = 1'b0;
    localparam logic HIGH_SPEED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter: counts enabled idle clocks and flags the last allowed one.
// Saturates at TIMEOUT_CLKS-1 so it can never wrap.
module rx_gap_timer #(
    parameter int TO_BIT       = 15,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TO_BIT-1:0] LAST_CNT = TO_BIT'(TIMEOUT_CLKS - 1);

    logic [TO_BIT-1:0] cnt_r;

    // Gap counter: clear wins, otherwise count enabled cycles up to the saturation point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TO_BIT{1'b0}};
        end else if (i_clear) begin
            cnt_r <= {TO_BIT{1'b0}};
        end else if (i_enable && (cnt_r != LAST_CNT)) begin
            cnt_r <= cnt_r + TO_BIT'(1);
        end
    end

    assign o_expire = i_enable & (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_packet_rx.sv
// Collects PACK_NUM UART bytes into a pattern, speed mask and command byte and
// presents them on a valid/ready handshake; partial packets time out.
module uart_packet_rx
    import uart_packet_rx_pkg::*;
#(
    parameter int DATA_BIT     = 32,
    parameter int PACK_NUM     = 9,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int TO_BIT       = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_done_tick,
    input  logic                i_pkt_ready,
    output logic                o_pkt_valid,
    output logic [DATA_BIT-1:0] o_data,
    output logic [DATA_BIT-1:0] o_speed,
    output logic [3:0]          o_channel,
    output logic                o_mode,
    output logic                o_stop,
    output logic                o_start,
    output logic [3:0]          o_byte_cnt,
    output logic                o_timeout_tick,
    output logic                o_overrun_tick
);

    // The command byte is consumed straight from the final strobe, so only the
    // pattern and speed bytes need buffering.
    localparam int         BUF_W    = 2 * DATA_BIT;
    localparam int         BUF_N    = PACK_NUM - 1;
    localparam logic [3:0] LAST_IDX = 4'(PACK_NUM - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         byte_cnt_r;
    logic [3:0]         byte_cnt_next_s;
    logic [BUF_W-1:0]   buf_r;
    logic               store_s;
    logic               load_s;
    logic               timeout_s;
    logic               overrun_s;
    logic               gap_clear_s;
    logic               gap_enable_s;
    logic               gap_expire_s;
    logic               pkt_valid_r;
    logic [DATA_BIT-1:0] data_r;
    logic [DATA_BIT-1:0] speed_r;
    logic [3:0]         channel_r;
    logic               mode_r;
    logic               stop_r;
    logic               start_r;
    logic               timeout_tick_r;
    logic               overrun_tick_r;

    assign gap_clear_s  = (state_r != ST_COLLECT) | i_rx_done_tick;
    assign gap_enable_s = (state_r == ST_COLLECT) & ~i_rx_done_tick;

    rx_gap_timer #(
        .TO_BIT       (TO_BIT),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (gap_clear_s),
        .i_enable (gap_enable_s),
        .o_expire (gap_expire_s)
    );

    // Next-state and per-cycle event decode; a strobe always beats gap expiry.
    always_comb begin
        state_next_s    = state_r;
        byte_cnt_next_s = byte_cnt_r;
        store_s         = 1'b0;
        load_s          = 1'b0;
        timeout_s       = 1'b0;
        overrun_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_rx_done_tick) begin
                    store_s         = 1'b1;
                    byte_cnt_next_s = 4'd1;
                    state_next_s    = ST_COLLECT;
                end else begin
                    byte_cnt_next_s = 4'd0;
                end
            end
            ST_COLLECT: begin
                if (i_rx_done_tick) begin
                    if (byte_cnt_r == LAST_IDX) begin
                        load_s       = 1'b1;
                        state_next_s = ST_HOLD;
                    end else begin
                        store_s         = 1'b1;
                        byte_cnt_next_s = byte_cnt_r + 4'd1;
                    end
                end else if (gap_expire_s) begin
                    timeout_s       = 1'b1;
                    byte_cnt_next_s = 4'd0;
                    state_next_s    = ST_IDLE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                overrun_s = i_rx_done_tick;
                if (pkt_valid_r && i_pkt_ready) begin
                    byte_cnt_next_s = 4'd0;
                    state_next_s    = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                byte_cnt_next_s = 4'd0;
                state_next_s    = ST_IDLE;
            end
        endcase
    end

    // State, byte counter, handshake and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            byte_cnt_r     <= 4'd0;
            pkt_valid_r    <= 1'b0;
            timeout_tick_r <= 1'b0;
            overrun_tick_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            byte_cnt_r     <= byte_cnt_next_s;
            pkt_valid_r    <= (state_next_s == ST_HOLD);
            timeout_tick_r <= timeout_s;
            overrun_tick_r <= overrun_s;
        end
    end

    // Byte buffer: byte i lands in bits [8i+7:8i]; a timeout discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_r <= {BUF_W{1'b0}};
        end else if (timeout_s) begin
            buf_r <= {BUF_W{1'b0}};
        end else if (store_s) begin
            for (int i = 0; i < BUF_N; i++) begin
                if (byte_cnt_r == 4'(i)) begin
                    buf_r[8*i +: 8] <= i_rx_data;
                end
            end
        end
    end

    // Held fields change only on entry to HOLD and survive the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= {DATA_BIT{1'b0}};
            speed_r   <= {DATA_BIT{1'b0}};
            channel_r <= 4'd0;
            mode_r    <= ONE_SHOT;
            stop_r    <= 1'b0;
            start_r   <= 1'b0;
        end else if (load_s) begin
            data_r    <= buf_r[DATA_BIT-1:0];
            speed_r   <= buf_r[BUF_W-1:DATA_BIT];
            channel_r <= i_rx_data[CMD_CH_MSB:CMD_CH_LSB];
            mode_r    <= i_rx_data[CMD_MODE];
            stop_r    <= i_rx_data[CMD_STOP];
            start_r   <= i_rx_data[CMD_START];
        end
    end

    assign o_pkt_valid    = pkt_valid_r;
    assign o_data         = data_r;
    assign o_speed        = speed_r;
    assign o_channel      = channel_r;
    assign o_mode         = mode_r;
    assign o_stop         = stop_r;
    assign o_start        = start_r;
    assign o_byte_cnt     = byte_cnt_r;
    assign o_timeout_tick = timeout_tick_r;
    assign o_overrun_tick = overrun_tick_r;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed bench for uart_packet_rx: a queue-based packet model checked every
// cycle, plus literal expectations for each scenario.
module tb_uart_packet_rx;

    localparam int DB = 32;
    localparam int PN = 9;
    localparam int TO = 20000;
    localparam int TB = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          strobe;
    logic          ready;
    logic          pkt_valid;
    logic [DB-1:0] data;
    logic [DB-1:0] speed;
    logic [3:0]    channel;
    logic          mode;
    logic          stop;
    logic          start;
    logic [3:0]    byte_cnt;
    logic          timeout_tick;
    logic          overrun_tick;

    int errors = 0;
    int checks = 0;

    uart_packet_rx #(
        .DATA_BIT     (DB),
        .PACK_NUM     (PN),
        .TIMEOUT_CLKS (TO),
        .TO_BIT       (TB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_done_tick (strobe),
        .i_pkt_ready    (ready),
        .o_pkt_valid    (pkt_valid),
        .o_data         (data),
        .o_speed        (speed),
        .o_channel      (channel),
        .o_mode         (mode),
        .o_stop         (stop),
        .o_start        (start),
        .o_byte_cnt     (byte_cnt),
        .o_timeout_tick (timeout_tick),
        .o_overrun_tick (overrun_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes pile up in a queue; a full queue becomes a packet.
    logic          m_valid;
    logic [DB-1:0] m_data;
    logic [DB-1:0] m_speed;
    logic [7:0]    m_cmd;
    int            m_bc;
    logic          m_to;
    logic          m_ov;
    logic [7:0]    q[$];
    int            gap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_speed = '0; m_cmd = 8'h00;
            m_bc = 0; m_to = 1'b0; m_ov = 1'b0; gap = 0;
            q.delete();
        end else begin
            m_to = 1'b0;
            m_ov = 1'b0;
            if (m_valid) begin
                if (strobe) m_ov = 1'b1;
                if (ready) begin
                    m_valid = 1'b0;
                    m_bc = 0;
                end
            end else if (strobe) begin
                q.push_back(rx_data);
                gap = 0;
                if (q.size() == PN) begin
                    for (int i = 0; i < DB/8; i++) begin
                        m_data[8*i +: 8]  = q[i];
                        m_speed[8*i +: 8] = q[DB/8 + i];
                    end
                    m_cmd   = q[PN-1];
                    m_valid = 1'b1;
                    m_bc    = PN - 1;
                    q.delete();
                end else begin
                    m_bc = q.size();
                end
            end else if (q.size() != 0) begin
                gap++;
                if (gap == TO) begin
                    m_to = 1'b1;
                    m_bc = 0;
                    gap  = 0;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid",   64'(pkt_valid),    64'(m_valid));
            chk("m_data",    64'(data),         64'(m_data));
            chk("m_speed",   64'(speed),        64'(m_speed));
            chk("m_channel", 64'(channel),      64'(m_cmd[6:3]));
            chk("m_mode",    64'(mode),         64'(m_cmd[2]));
            chk("m_stop",    64'(stop),         64'(m_cmd[1]));
            chk("m_start",   64'(start),        64'(m_cmd[0]));
            chk("m_bytecnt", 64'(byte_cnt),     64'(m_bc));
            chk("m_timeout", 64'(timeout_tick), 64'(m_to));
            chk("m_overrun", 64'(overrun_tick), 64'(m_ov));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        strobe  = 1'b1;
        @(posedge clk);
        #1;
        strobe  = 1'b0;
    endtask

    task automatic send_bytes(input logic [8*PN-1:0] pk, input int n, input int gap_clks);
        for (int i = 0; i < n; i++) begin
            send_byte(pk[8*i +: 8]);
            if (i < n - 1) idle(gap_clks);
        end
    endtask

    task automatic check_pkt(input string name, input logic [31:0] d, input logic [31:0] s,
                             input logic [3:0] ch, input logic md, input logic sp, input logic st);
        chk({name, "_valid"},   64'(pkt_valid), 64'(1'b1));
        chk({name, "_data"},    64'(data),      64'(d));
        chk({name, "_speed"},   64'(speed),     64'(s));
        chk({name, "_channel"}, 64'(channel),   64'(ch));
        chk({name, "_mode"},    64'(mode),      64'(md));
        chk({name, "_stop"},    64'(stop),      64'(sp));
        chk({name, "_start"},   64'(start),     64'(st));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"},   64'(pkt_valid),    64'h0);
        chk({name, "_data"},    64'(data),         64'h0);
        chk({name, "_speed"},   64'(speed),        64'h0);
        chk({name, "_cmd"},     64'({channel, mode, stop, start}), 64'h0);
        chk({name, "_bytecnt"}, 64'(byte_cnt),     64'h0);
        chk({name, "_ticks"},   64'({timeout_tick, overrun_tick}), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nto;
        logic [8*PN-1:0] pk1;
        logic [8*PN-1:0] pk2;
        logic [8*PN-1:0] pk3;
        logic [8*PN-1:0] pk4;
        logic [8*PN-1:0] pk5;
        logic [8*PN-1:0] pk6;
        pk1 = 72'h01_FF_00_FF_00_55_FF_00_FF;
        pk2 = 72'h2E_FF_00_FF_00_55_FF_00_FF;
        pk3 = 72'h7B_55_AA_0F_F0_04_03_02_01;
        pk4 = 72'h09_88_77_66_55_44_33_22_11;
        pk5 = 72'h04_80_00_00_00_EF_BE_AD_DE;
        pk6 = 72'h52_78_56_34_12_3C_C3_5A_A5;

        rst_n = 1'b0; strobe = 1'b0; ready = 1'b0; rx_data = 8'h00;
        #1;
        check_all_zero("reset");
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // T1: one-cycle valid with ready high
        ready = 1'b1;
        send_bytes(pk1, PN, 3);
        check_pkt("t1", 32'h55FF00FF, 32'hFF00FF00, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_bytecnt_hold", 64'(byte_cnt), 64'd8);
        idle(1);
        chk("t1_valid_drop", 64'(pkt_valid), 64'h0);
        chk("t1_bytecnt_clr", 64'(byte_cnt), 64'h0);
        idle(3);

        // T2: held packet under back-pressure
        ready = 1'b0;
        send_bytes(pk2, PN, 2);
        idle(1000);
        check_pkt("t2", 32'h55FF00FF, 32'hFF00FF00, 4'd5, 1'b1, 1'b1, 1'b0);
        ready = 1'b1;
        idle(1);
        chk("t2_valid_drop", 64'(pkt_valid), 64'h0);
        chk("t2_fields_kept", 64'(channel), 64'd5);
        idle(3);

        // T3: partial packet times out, next packet is clean
        send_bytes(pk1, 4, 2);
        chk("t3_bytecnt4", 64'(byte_cnt), 64'd4);
        nto = 0;
        for (int i = 0; i < TO + 10; i++) begin
            idle(1);
            if (timeout_tick) nto++;
        end
        chk("t3_timeout_once", 64'(nto), 64'd1);
        chk("t3_bytecnt0", 64'(byte_cnt), 64'h0);
        send_bytes(pk3, PN, 2);
        check_pkt("t3", 32'h04030201, 32'h55AA0FF0, 4'hF, 1'b0, 1'b1, 1'b1);
        idle(3);

        // T4: strobe on the expiry cycle wins over the timeout
        send_bytes(pk4, 2, 1);
        nto = 0;
        for (int i = 0; i < TO - 1; i++) begin
            idle(1);
            if (timeout_tick) nto++;
        end
        chk("t4_no_early_timeout", 64'(nto), 64'h0);
        chk("t4_bytecnt2", 64'(byte_cnt), 64'd2);
        send_byte(pk4[23:16]);
        chk("t4_bytecnt3", 64'(byte_cnt), 64'd3);
        chk("t4_no_timeout", 64'(timeout_tick), 64'h0);
        for (int i = 3; i < PN; i++) begin
            idle(1);
            send_byte(pk4[8*i +: 8]);
        end
        check_pkt("t4", 32'h44332211, 32'h88776655, 4'd1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // T5: overrun in HOLD and on the accept cycle
        ready = 1'b0;
        send_bytes(pk5, PN, 2);
        check_pkt("t5_hold", 32'hEFBEADDE, 32'h80000000, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        send_byte(8'hAA);
        chk("t5_overrun1", 64'(overrun_tick), 64'h1);
        check_pkt("t5_after_ov", 32'hEFBEADDE, 32'h80000000, 4'd0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t5_overrun_pulse", 64'(overrun_tick), 64'h0);
        ready = 1'b1;
        send_byte(8'hAA);
        chk("t5_overrun2", 64'(overrun_tick), 64'h1);
        chk("t5_accept", 64'(pkt_valid), 64'h0);
        chk("t5_data_kept", 64'(data), 64'hEFBEADDE);
        chk("t5_bytecnt", 64'(byte_cnt), 64'h0);
        idle(2);
        send_bytes(pk1, PN, 2);
        check_pkt("t5_next", 32'h55FF00FF, 32'hFF00FF00, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // T6: asynchronous reset mid-packet
        send_bytes(pk6, 6, 2);
        chk("t6_bytecnt6", 64'(byte_cnt), 64'd6);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send_bytes(pk6, PN, 2);
        check_pkt("t6", 32'h3CC35AA5, 32'h78563412, 4'hA, 1'b0, 1'b1, 1'b0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
